// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction memory loader.
// The master is the byte source; the slave is the loader.
interface imem_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles little-endian words from a byte stream and writes
// them to consecutive instruction memory words while holding the core stalled.
module imem_loader #(
    parameter int DEPTH_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DEPTH_W:0]   len,
    input  logic               abort,
    imem_loader_if.slave       stream,
    output logic               we,
    output logic [31:0]        waddr,
    output logic [31:0]        wdata,
    output logic               cpu_stall,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    localparam logic [DEPTH_W:0] CAP = {1'b1, {DEPTH_W{1'b0}}};

    state_t             state;
    state_t             state_next;
    logic [DEPTH_W:0]   len_q;
    logic [DEPTH_W:0]   len_clamped;
    logic [1:0]         byte_cnt;
    logic [DEPTH_W-1:0] word_idx;
    logic [31:0]        buffer;
    logic               accept;
    logic               last_word;

    assign accept      = (state == RECV) && stream.byte_valid;
    assign last_word   = (({1'b0, word_idx} + (DEPTH_W+1)'(1)) == len_q);
    assign len_clamped = (len > CAP) ? CAP : len;
    assign waddr       = 32'({word_idx, 2'b00});
    assign wdata       = buffer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort overrides every transition and suppresses the write of the current cycle.
    always_comb begin
        state_next        = state;
        stream.byte_ready = 1'b0;
        we                = 1'b0;
        busy              = 1'b0;
        cpu_stall         = 1'b0;
        done              = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                stream.byte_ready = 1'b1;
                busy              = 1'b1;
                cpu_stall         = 1'b1;
                if (accept && (byte_cnt == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                we         = 1'b1;
                busy       = 1'b1;
                cpu_stall  = 1'b1;
                state_next = last_word ? DONE : RECV;
            end
            DONE: begin
                done       = 1'b1;
                cpu_stall  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
            we         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            buffer   <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= len_clamped;
                        byte_cnt <= '0;
                        word_idx <= '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        buffer[{byte_cnt, 3'b000} +: 8] <= stream.byte_data;
                        byte_cnt                        <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_idx <= word_idx + DEPTH_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
